manchester_encoder_tx: RTL and testbench



---
 rtl/manchester_pkg.sv | 23 ++
 rtl/manchester_bit_symbol.sv | 24 ++
 rtl/manchester_encoder_tx.sv | 127 ++++++++++++
 tb/tb_manchester_encoder_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Line-code definitions shared by the Manchester transmitter and receiver,
// so symbol polarity and idle level are defined in exactly one place.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        GAP
    } tx_state_t;

    localparam logic [1:0] SYM_ONE    = 2'b01;
    localparam logic [1:0] SYM_ZERO   = 2'b10;
    localparam logic       IDLE_LEVEL = 1'b0;

    // phase 0 selects the first half of the symbol, phase 1 the second
    function automatic logic half_level(input logic bit_val, input logic phase);
        logic [1:0] sym;
        sym = bit_val ? SYM_ONE : SYM_ZERO;
        return phase ? sym[0] : sym[1];
    endfunction

endpackage

// File: rtl/manchester_bit_symbol.sv
// Registered half-bit line level: encodes one bit at the given phase,
// or holds the idle level when the serializer is not transmitting.
module manchester_bit_symbol
    import manchester_pkg::*;
(
    input  logic clk2x,
    input  logic rst_n,
    input  logic active,
    input  logic bit_val,
    input  logic phase,
    output logic level
);

    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            level <= IDLE_LEVEL;
        end else if (active) begin
            level <= half_level(bit_val, phase);
        end else begin
            level <= IDLE_LEVEL;
        end
    end

endmodule

// File: rtl/manchester_encoder_tx.sv
// Frame-level Manchester transmitter: preamble of logical zeros, MSB-first
// data bytes from a one-deep holding register, then a forced idle gap.
module manchester_encoder_tx
    import manchester_pkg::*;
#(
    parameter int PREAMBLE_BITS = 8,
    parameter int GAP_BITS      = 4
) (
    input  logic       clk2x,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dout,
    output logic       busy,
    output logic       underrun
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);

    tx_state_t  state, state_nxt;
    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_full, hold_full_nxt;
    logic [7:0] shift_reg;
    logic       cur_last;
    logic [2:0] bit_idx;
    logic [7:0] cnt;
    logic       phase;
    logic       accept, load, underrun_nxt;
    logic       sym_active, sym_bit, line;

    assign accept = tx_valid && tx_ready;

    always_comb begin
        state_nxt    = state;
        load         = 1'b0;
        underrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                if (phase && cnt == PRE_LAST) begin
                    load      = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (phase && bit_idx == 3'd7) begin
                    if (cur_last) begin
                        state_nxt = GAP;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt    = GAP;
                        underrun_nxt = 1'b1;
                    end
                end
            end
            GAP: begin
                if (phase && cnt == GAP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        hold_full_nxt = (hold_full && !load) || accept;
    end

    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_data <= 8'h00;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            tx_ready  <= 1'b1;
            shift_reg <= 8'h00;
            cur_last  <= 1'b0;
            bit_idx   <= 3'd0;
            cnt       <= 8'd0;
            phase     <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_full <= hold_full_nxt;
            tx_ready  <= !hold_full_nxt;
            underrun  <= underrun_nxt;
            if (accept) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
            end
            // every state change lands on a phase-1 cycle, so toggling realigns to 0
            phase <= (state == IDLE) ? 1'b0 : ~phase;
            if (state_nxt != state) begin
                cnt <= 8'd0;
            end else if (phase && (state == PREAMBLE || state == GAP)) begin
                cnt <= cnt + 8'd1;
            end
            if (load) begin
                shift_reg <= hold_data;
                cur_last  <= hold_last;
                bit_idx   <= 3'd0;
            end else if (state == DATA && phase) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    assign sym_active = (state == PREAMBLE) || (state == DATA);
    assign sym_bit    = (state == DATA) ? shift_reg[7] : 1'b0;

    manchester_bit_symbol u_symbol (
        .clk2x   (clk2x),
        .rst_n   (rst_n),
        .active  (sym_active),
        .bit_val (sym_bit),
        .phase   (phase),
        .level   (line)
    );

    assign dout = enable ? line : 1'bz;
    assign busy = enable ? (state != IDLE) : 1'bz;

endmodule

// File: tb/tb_manchester_encoder_tx.sv
// Bench for manchester_encoder_tx: queue-based frame model compared every
// cycle, plus literal expectations for the directed frames.
module tb_manchester_encoder_tx;

    localparam int PB = 4;
    localparam int GB = 2;

    logic       clk2x = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, underrun;
    wire        dout, busy;

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int und_cnt = 0;

    always #5 clk2x = ~clk2x;

    manchester_encoder_tx #(.PREAMBLE_BITS(PB), .GAP_BITS(GB)) dut (
        .clk2x    (clk2x),
        .rst_n    (rst_n),
        .enable   (enable),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .dout     (dout),
        .busy     (busy),
        .underrun (underrun)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    // Frame model: a queue of upcoming line levels; decisions are taken only
    // when the queue drains (end of preamble, end of byte, end of gap).
    logic       m_q[$];
    int         m_mode = 0;   // 0 idle, 1 preamble, 2 data, 3 gap
    logic       m_hfull = 1'b0, m_hlast = 1'b0, m_cur_last = 1'b0;
    logic [7:0] m_hdata = 8'h00;
    logic       m_level = 1'b0, m_dout = 1'b0, m_busy = 1'b0, m_und = 1'b0, m_ready = 1'b1;

    always @(posedge clk2x or negedge rst_n) begin : model
        logic acc, ld;
        if (!rst_n) begin
            m_q.delete();
            m_mode = 0; m_hfull = 1'b0; m_cur_last = 1'b0;
            m_level = 1'b0; m_dout = 1'b0; m_busy = 1'b0; m_und = 1'b0; m_ready = 1'b1;
        end else begin
            acc = tx_valid && !m_hfull;
            ld = 1'b0;
            m_dout = m_level;
            m_und = 1'b0;
            if (m_q.size() == 0) begin
                if (m_mode == 0) begin
                    if (m_hfull) begin
                        for (int i = 0; i < PB; i++) begin m_q.push_back(1'b1); m_q.push_back(1'b0); end
                        m_mode = 1;
                    end
                end else if (m_mode == 3) begin
                    m_mode = 0;
                end else if (m_mode == 2 && m_cur_last) begin
                    for (int i = 0; i < 2 * GB; i++) m_q.push_back(1'b0);
                    m_mode = 3;
                end else if (m_hfull) begin
                    for (int i = 7; i >= 0; i--) begin m_q.push_back(~m_hdata[i]); m_q.push_back(m_hdata[i]); end
                    m_cur_last = m_hlast;
                    ld = 1'b1;
                    m_mode = 2;
                end else begin
                    m_und = 1'b1;
                    for (int i = 0; i < 2 * GB; i++) m_q.push_back(1'b0);
                    m_mode = 3;
                end
            end
            m_level = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
            m_busy = (m_mode != 0);
            if (ld) m_hfull = 1'b0;
            if (acc) begin m_hfull = 1'b1; m_hdata = tx_data; m_hlast = tx_last; end
            m_ready = !m_hfull;
        end
    end

    always @(negedge clk2x) begin
        if (rst_n) begin
            chk("tx_ready", tx_ready, m_ready);
            chk("underrun", underrun, m_und);
            if (enable) begin
                chk("dout", dout, m_dout);
                chk("busy", busy, m_busy);
            end else if (m_busy) begin
                chk("busy_undriven", busy === 1'b1, 1'b0);
            end
            if (busy === 1'b1) busy_cnt++;
            if (underrun === 1'b1) und_cnt++;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        logic r;
        n = 0;
        @(posedge clk2x); #1;
        tx_valid = 1'b1; tx_data = d; tx_last = l;
        do begin
            @(negedge clk2x); r = tx_ready;
            @(posedge clk2x); #1; n++;
        end while (!r && n < 200);
        if (!r) chk("send_timeout", 32'd0, 32'd1);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        tx_last = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_mode != 0 || m_hfull) && n < 1000) begin @(posedge clk2x); #1; n++; end
        if (n >= 1000) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk2x);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [27:0] a5_exp;
        logic [7:0]  lb_bytes[16];
        logic        cap[300];
        int b0, u0, s, errs;
        logic [7:0] rx;

        // reset values
        #13;
        chk("rst_dout", dout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_underrun", underrun, 1'b0);
        @(negedge clk2x); rst_n = 1'b1;
        repeat (3) @(posedge clk2x);

        // single byte 0xA5 with last: literal line pattern
        a5_exp = 28'b1010_1010_0110_0110_1001_1001_0000;
        b0 = busy_cnt; u0 = und_cnt;
        send(8'hA5, 1'b1);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk2x);
            if (i >= 2 && i < 30) chk("a5_dout", dout, a5_exp[29 - i]);
            else chk("a5_dout_idle", dout, 1'b0);
        end
        wait_idle();
        chk("a5_busy_cycles", busy_cnt - b0, 28);
        chk("a5_underruns", und_cnt - u0, 0);

        // back-to-back 0xFF, 0x00(last): no idle gap between bytes
        b0 = busy_cnt; u0 = und_cnt;
        send(8'hFF, 1'b0);
        send(8'h00, 1'b1);
        wait_idle();
        chk("b2b_busy_cycles", busy_cnt - b0, 2 * PB + 32 + 2 * GB);
        chk("b2b_underruns", und_cnt - u0, 0);

        // underrun: 0x3C without last
        b0 = busy_cnt; u0 = und_cnt;
        send(8'h3C, 1'b0);
        wait_idle();
        chk("ur_busy_cycles", busy_cnt - b0, 28);
        chk("ur_underruns", und_cnt - u0, 1);

        // reset mid-frame, then a clean 0x81 frame
        send(8'h5A, 1'b1);
        repeat (18) @(posedge clk2x);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", tx_ready, 1'b1);
        @(negedge clk2x); rst_n = 1'b1;
        b0 = busy_cnt; u0 = und_cnt;
        send(8'h81, 1'b1);
        wait_idle();
        chk("post_rst_busy_cycles", busy_cnt - b0, 28);
        chk("post_rst_underruns", und_cnt - u0, 0);

        // outputs disabled for a whole underrun frame
        @(posedge clk2x); #1 enable = 1'b0;
        b0 = busy_cnt; u0 = und_cnt;
        send(8'h3C, 1'b0);
        wait_idle();
        chk("dis_busy_seen", busy_cnt - b0, 0);
        chk("dis_underruns", und_cnt - u0, 1);

        // enable raised mid-frame: model compare resumes on the live stream
        send(8'hC3, 1'b1);
        repeat (14) @(posedge clk2x);
        #1 enable = 1'b1;
        wait_idle();

        // loopback: 16 random bytes in one frame, decoded from the line
        for (int j = 0; j < 16; j++) lb_bytes[j] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 300; i++) begin @(negedge clk2x); cap[i] = dout; end
            end
            begin
                for (int j = 0; j < 16; j++) send(lb_bytes[j], j == 15);
            end
        join
        s = 0;
        while (s < 40 && cap[s] !== 1'b1) s++;
        chk("lb_start_found", s < 30, 1'b1);
        if (s < 30) begin
            errs = 0;
            for (int j = 0; j < 16; j++) begin
                rx = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    if (cap[s + 2 * PB + 16 * j + 2 * k] === cap[s + 2 * PB + 16 * j + 2 * k + 1]) errs++;
                    rx = {rx[6:0], cap[s + 2 * PB + 16 * j + 2 * k + 1]};
                end
                chk("lb_byte", rx, lb_bytes[j]);
            end
            chk("lb_symbol_errors", errs, 0);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
